// File: rtl/accu_pkg.sv
// Shared constants, FSM state type and byte-select helper for the accumulator feeder.
package accu_pkg;

    localparam int BYTE_W    = 8;
    localparam int GROUP_LEN = 4;
    localparam int SUM_W     = 10;
    localparam int GROUP_W   = BYTE_W * GROUP_LEN;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [BYTE_W-1:0] group_byte(input logic [GROUP_W-1:0] grp,
                                                     input logic [1:0]         idx);
        return grp[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/accu_group_fifo.sv
// Synchronous group FIFO with a head read port and a look-ahead port for the entry behind the head.
module accu_group_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_next,
    output logic             full,
    output logic             empty,
    output logic             multi
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign multi   = (count_q > CW'(1));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_next = mem_q[rd_ptr_q + AW'(1)];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/accu_feeder.sv
// Serialises buffered 32-bit groups into bytes for an accumulator.
// Optional per-group byte sum enabled by defining ACCU_FEEDER_SUM_EN.
module accu_feeder
    import accu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        out_ready,
    output logic        last_out,
    output logic [9:0]  sum_out,
    output logic        sum_valid
);

    logic [GROUP_W-1:0] head, head_next, next_grp;
    logic               fifo_full, fifo_empty, fifo_multi;
    logic               push, pop, xfer, next_avail;

    logic               up_q, up_d;
    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [BYTE_W-1:0]  data_out_q, data_out_d;
    logic               valid_out_q, valid_out_d;
    logic               last_out_q, last_out_d;

    assign ready_in  = up_q & ~fifo_full;
    assign push      = valid_in & ready_in;
    assign xfer      = valid_out_q & out_ready;
    assign pop       = xfer & (idx_q == 2'd3);
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;

    // The group behind the head is either already buffered or arriving this very cycle.
    assign next_avail = fifo_multi | push;
    assign next_grp   = fifo_multi ? head_next : data_in;

    accu_group_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (GROUP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (head),
        .rd_next (head_next),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .multi   (fifo_multi)
    );

    always_comb begin
        up_d        = 1'b1;
        state_d     = state_q;
        idx_d       = idx_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d     = SEND;
                    idx_d       = 2'd0;
                    data_out_d  = group_byte(head, 2'd0);
                    valid_out_d = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        data_out_d = group_byte(head, idx_q + 2'd1);
                    end else if (next_avail) begin
                        idx_d      = 2'd0;
                        data_out_d = group_byte(next_grp, 2'd0);
                    end else begin
                        state_d     = IDLE;
                        idx_d       = 2'd0;
                        data_out_d  = '0;
                        valid_out_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_out_d = valid_out_d & (idx_d == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q        <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            up_q        <= up_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

`ifdef ACCU_FEEDER_SUM_EN
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_out_q, sum_out_d;
    logic             done_q, done_d;
    logic             sum_valid_q, sum_valid_d;

    // Byte 0 seeds the running sum; the result publishes one edge after byte 3 leaves.
    always_comb begin
        acc_d = acc_q;
        if (xfer) begin
            acc_d = (idx_q == 2'd0) ? SUM_W'(data_out_q) : acc_q + SUM_W'(data_out_q);
        end
        done_d      = pop;
        sum_valid_d = done_q;
        sum_out_d   = done_q ? acc_q : sum_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            done_q      <= 1'b0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            done_q      <= done_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;
`else
    assign sum_out   = '0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_accu_feeder.sv
// Randomised self-checking bench for accu_feeder against a group/byte-stream reference model.
module tb_accu_feeder;

    localparam int DEPTH = 2;

    typedef logic [31:0] grp_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        out_ready;
    logic        last_out;
    logic [9:0]  sum_out;
    logic        sum_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [8:0] exp_bytes[$];
    logic [8:0] obs_bytes[$];
    int         obs_cyc[$];
    int         acc_cyc[$];
    logic [9:0] exp_sums[$];
    logic [9:0] obs_sums[$];
    int         exp_sum_cyc[$];
    int         obs_sum_cyc[$];

    int         cyc = 0;
    int         occ = 0;
    int         n_xfer = 0;
    int         ready_err = 0;
    int         hold_err = 0;
    int         sum_tie_err = 0;
    logic       up_q = 1'b0;
    logic       stalled = 1'b0;
    logic [9:0] held = '0;
    logic       ready_low_seen = 1'b0;

    accu_feeder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .last_out  (last_out),
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Observe handshakes before each rising edge and advance the reference model.
    task automatic step(output logic accepted);
        logic       xfer;
        logic [7:0] b;
        int         s;
        @(negedge clk);
        if (ready_in !== (up_q && occ < DEPTH)) ready_err++;
        if (ready_in === 1'b0) ready_low_seen = 1'b1;
        if (stalled && ({valid_out, last_out, data_out} !== held)) hold_err++;
        if (sum_valid === 1'b1) begin
            obs_sums.push_back(sum_out);
            obs_sum_cyc.push_back(cyc);
        end
        if (sum_valid !== 1'b0 || sum_out !== 10'd0) sum_tie_err++;
        accepted = (valid_in === 1'b1) && (ready_in === 1'b1);
        xfer     = (valid_out === 1'b1) && (out_ready === 1'b1);
        if (accepted) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                b = data_in[8*k +: 8];
                exp_bytes.push_back({1'(k == 3), b});
                s += int'(b);
            end
            exp_sums.push_back(10'(s));
            acc_cyc.push_back(cyc);
            occ++;
        end
        if (xfer) begin
            obs_bytes.push_back({last_out, data_out});
            obs_cyc.push_back(cyc);
            if (n_xfer % 4 == 3) begin
                occ--;
                exp_sum_cyc.push_back(cyc + 2);
            end
            n_xfer++;
        end
        stalled = (valid_out === 1'b1) && (out_ready === 1'b0);
        held    = {valid_out, last_out, data_out};
        @(posedge clk);
        up_q = rst_n;
        cyc++;
        #1;
    endtask

    task automatic clear_queues();
        exp_bytes.delete();   obs_bytes.delete();  obs_cyc.delete();  acc_cyc.delete();
        exp_sums.delete();    obs_sums.delete();   exp_sum_cyc.delete(); obs_sum_cyc.delete();
        sum_tie_err = 0;
        ready_low_seen = 1'b0;
    endtask

    task automatic drive(input grp_q_t grps, input int pvalid, input int pready,
                         input int budget, output logic timed_out);
        int   i;
        int   n;
        logic acc;
        i = 0;
        n = 0;
        while (!(i == grps.size() && obs_bytes.size() == exp_bytes.size()) && n < budget) begin
            if (i < grps.size() && $urandom_range(99) < pvalid) begin
                valid_in = 1'b1;
                data_in  = grps[i];
            end else begin
                valid_in = 1'b0;
                data_in  = $urandom;
            end
            out_ready = ($urandom_range(99) < pready);
            step(acc);
            if (acc) i++;
            n++;
        end
        timed_out = !(i == grps.size() && obs_bytes.size() == exp_bytes.size());
        valid_in  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(acc);
    endtask

    task automatic test_reset();
        logic acc;
        rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (ready_in !== 1'b0) $display("[TB] FAIL reset_ready actual=%b required=0", ready_in); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h00) $display("[TB] FAIL reset_data actual=%h required=00", data_out); else pass_cnt++;
        total_cnt++; if (valid_out !== 1'b0) $display("[TB] FAIL reset_valid actual=%b required=0", valid_out); else pass_cnt++;
        total_cnt++; if (last_out !== 1'b0) $display("[TB] FAIL reset_last actual=%b required=0", last_out); else pass_cnt++;
        total_cnt++; if ({sum_valid, sum_out} !== 11'd0) $display("[TB] FAIL reset_sum actual=%b/%h required=0/000", sum_valid, sum_out); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (ready_in !== 1'b0) $display("[TB] FAIL ready_before_edge actual=%b required=0", ready_in); else pass_cnt++;
        step(acc);
        total_cnt++; if (ready_in !== 1'b1) $display("[TB] FAIL ready_after_edge actual=%b required=1", ready_in); else pass_cnt++;
    endtask

    task automatic test_single();
        grp_q_t g;
        logic   tmo;
        clear_queues();
        g = '{32'h04030201};
        drive(g, 100, 100, 50, tmo);
        total_cnt++; if (tmo) $display("[TB] FAIL single_timeout actual=%0d bytes required=4", obs_bytes.size()); else pass_cnt++;
        total_cnt++; if (obs_bytes.size() != 4) $display("[TB] FAIL single_count actual=%0d required=4", obs_bytes.size()); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL single_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_cyc.size() < 4 || obs_cyc[0] != acc_cyc[0] + 2 || obs_cyc[3] != obs_cyc[0] + 3)
            $display("[TB] FAIL single_timing actual_first=%0d required_first=%0d", obs_cyc.size() > 0 ? obs_cyc[0] : -1, acc_cyc[0] + 2);
        else pass_cnt++;
`ifdef ACCU_FEEDER_SUM_EN
        total_cnt++;
        if (obs_sums.size() != 1 || obs_sums[0] !== 10'h00A || obs_sum_cyc[0] != exp_sum_cyc[0])
            $display("[TB] FAIL single_sum actual_pulses=%0d actual=%h required=00A", obs_sums.size(), obs_sums.size() > 0 ? obs_sums[0] : 10'h0);
        else pass_cnt++;
`else
        total_cnt++; if (sum_tie_err != 0) $display("[TB] FAIL single_sum_tied actual=%0d nonzero cycles required=0", sum_tie_err); else pass_cnt++;
`endif
    endtask

    task automatic test_max_sum();
        grp_q_t g;
        logic   tmo;
        clear_queues();
        g = '{32'hFFFFFFFF};
        drive(g, 100, 100, 50, tmo);
        total_cnt++; if (tmo) $display("[TB] FAIL max_timeout actual=%0d bytes required=4", obs_bytes.size()); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL max_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
`ifdef ACCU_FEEDER_SUM_EN
        total_cnt++;
        if (obs_sums.size() != 1 || obs_sums[0] !== 10'h3FC)
            $display("[TB] FAIL max_sum actual_pulses=%0d actual=%h required=3FC", obs_sums.size(), obs_sums.size() > 0 ? obs_sums[0] : 10'h0);
        else pass_cnt++;
`else
        total_cnt++; if (sum_tie_err != 0) $display("[TB] FAIL max_sum_tied actual=%0d nonzero cycles required=0", sum_tie_err); else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        grp_q_t g;
        logic   tmo;
        clear_queues();
        ready_err = 0;
        g = '{$urandom, $urandom, $urandom};
        drive(g, 100, 100, 60, tmo);
        total_cnt++; if (tmo) $display("[TB] FAIL b2b_timeout actual=%0d bytes required=12", obs_bytes.size()); else pass_cnt++;
        total_cnt++; if (!ready_low_seen) $display("[TB] FAIL b2b_full actual=ready never low required=ready low when full"); else pass_cnt++;
        total_cnt++; if (ready_err != 0) $display("[TB] FAIL b2b_ready actual=%0d bad cycles required=0", ready_err); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i] || obs_cyc[i] != obs_cyc[0] + i)
                $display("[TB] FAIL b2b_byte%0d actual=%h@%0d required=%h@%0d", i, obs_bytes[i], obs_cyc[i], exp_bytes[i], obs_cyc[0] + i);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic acc;
        int   n;
        clear_queues();
        hold_err = 0;
        valid_in = 1'b1; data_in = $urandom; out_ready = 1'b1;
        n = 0;
        do begin step(acc); n++; end while (!acc && n < 20);
        valid_in = 1'b0;
        while (obs_bytes.size() < 2 && n < 40) begin step(acc); n++; end
        out_ready = 1'b0;
        repeat (3) step(acc);
        total_cnt++; if (valid_out !== 1'b1 || obs_bytes.size() != 2) $display("[TB] FAIL stall_held actual valid=%b bytes=%0d required valid=1 bytes=2", valid_out, obs_bytes.size()); else pass_cnt++;
        out_ready = 1'b1;
        while (obs_bytes.size() < 4 && n < 60) begin step(acc); n++; end
        repeat (4) step(acc);
        total_cnt++; if (hold_err != 0) $display("[TB] FAIL stall_stable actual=%0d changes required=0", hold_err); else pass_cnt++;
        total_cnt++; if (obs_bytes.size() != 4) $display("[TB] FAIL stall_count actual=%0d required=4", obs_bytes.size()); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL stall_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
`ifdef ACCU_FEEDER_SUM_EN
        total_cnt++;
        if (obs_sums.size() != 1 || obs_sums[0] !== exp_sums[0] || obs_sum_cyc[0] != exp_sum_cyc[0])
            $display("[TB] FAIL stall_sum actual_pulses=%0d actual=%h required=%h", obs_sums.size(), obs_sums.size() > 0 ? obs_sums[0] : 10'h0, exp_sums[0]);
        else pass_cnt++;
`endif
    endtask

    task automatic test_simultaneous();
        logic acc;
        int   n;
        clear_queues();
        ready_err = 0;
        valid_in = 1'b1; data_in = $urandom; out_ready = 1'b1;
        n = 0;
        do begin step(acc); n++; end while (!acc && n < 20);
        valid_in = 1'b0;
        while (obs_bytes.size() < 3 && n < 40) begin step(acc); n++; end
        valid_in = 1'b1; data_in = $urandom;
        step(acc);
        total_cnt++;
        if (!acc || obs_bytes.size() != 4) $display("[TB] FAIL simul_event actual accept=%b bytes=%0d required accept=1 bytes=4", acc, obs_bytes.size());
        else pass_cnt++;
        out_ready = 1'b0; data_in = $urandom;
        n = 0;
        do begin step(acc); n++; end while (!acc && n < 20);
        data_in = $urandom;
        repeat (3) step(acc);
        total_cnt++; if (acc) $display("[TB] FAIL simul_full actual accept=1 required accept=0"); else pass_cnt++;
        out_ready = 1'b1;
        n = 0;
        while (!acc && n < 40) begin step(acc); n++; end
        valid_in = 1'b0;
        while (obs_bytes.size() < exp_bytes.size() && n < 80) begin step(acc); n++; end
        repeat (3) step(acc);
        total_cnt++; if (ready_err != 0) $display("[TB] FAIL simul_ready actual=%0d bad cycles required=0", ready_err); else pass_cnt++;
        total_cnt++; if (obs_bytes.size() != 16) $display("[TB] FAIL simul_count actual=%0d required=16", obs_bytes.size()); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL simul_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        grp_q_t g;
        logic   tmo;
        clear_queues();
        ready_err = 0;
        hold_err = 0;
        for (int k = 0; k < 10; k++) g.push_back($urandom);
        drive(g, 50, 60, 600, tmo);
        total_cnt++; if (tmo) $display("[TB] FAIL rand_timeout actual=%0d bytes required=40", obs_bytes.size()); else pass_cnt++;
        total_cnt++; if (ready_err != 0 || hold_err != 0) $display("[TB] FAIL rand_protocol actual ready_err=%0d hold_err=%0d required=0/0", ready_err, hold_err); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL rand_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
`ifdef ACCU_FEEDER_SUM_EN
        total_cnt++; if (obs_sums.size() != exp_sums.size()) $display("[TB] FAIL rand_sum_count actual=%0d required=%0d", obs_sums.size(), exp_sums.size()); else pass_cnt++;
        foreach (exp_sums[i]) begin
            total_cnt++;
            if (obs_sums[i] !== exp_sums[i] || obs_sum_cyc[i] != exp_sum_cyc[i])
                $display("[TB] FAIL rand_sum%0d actual=%h@%0d required=%h@%0d", i, obs_sums[i], obs_sum_cyc[i], exp_sums[i], exp_sum_cyc[i]);
            else pass_cnt++;
        end
`else
        total_cnt++; if (sum_tie_err != 0) $display("[TB] FAIL rand_sum_tied actual=%0d nonzero cycles required=0", sum_tie_err); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        grp_q_t g;
        logic   acc;
        logic   tmo;
        int     n;
        clear_queues();
        valid_in = 1'b1; data_in = $urandom; out_ready = 1'b1;
        n = 0;
        do begin step(acc); n++; end while (!acc && n < 20);
        valid_in = 1'b0;
        while (obs_bytes.size() < 2 && n < 40) begin step(acc); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ready_in, valid_out, last_out, data_out} !== 11'd0)
            $display("[TB] FAIL midreset_outputs actual ready=%b valid=%b last=%b data=%h required all 0", ready_in, valid_out, last_out, data_out);
        else pass_cnt++;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (sum_valid !== 1'b0) obs_sums.push_back(sum_out);
        end
        total_cnt++; if (obs_sums.size() != 0) $display("[TB] FAIL midreset_nosum actual=%0d pulses required=0", obs_sums.size()); else pass_cnt++;
        rst_n = 1'b1;
        occ = 0; n_xfer = 0; up_q = 1'b0; stalled = 1'b0;
        clear_queues();
        g = '{$urandom};
        drive(g, 100, 100, 50, tmo);
        total_cnt++; if (tmo) $display("[TB] FAIL midreset_timeout actual=%0d bytes required=4", obs_bytes.size()); else pass_cnt++;
        foreach (exp_bytes[i]) begin
            total_cnt++;
            if (obs_bytes[i] !== exp_bytes[i]) $display("[TB] FAIL midreset_byte%0d actual=%h required=%h", i, obs_bytes[i], exp_bytes[i]);
            else pass_cnt++;
        end
`ifdef ACCU_FEEDER_SUM_EN
        total_cnt++;
        if (obs_sums.size() != 1 || obs_sums[0] !== exp_sums[0])
            $display("[TB] FAIL midreset_sum actual_pulses=%0d required=1 value=%h", obs_sums.size(), exp_sums[0]);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_sum();
        test_back_to_back();
        test_stall();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
